// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's external signals. It carries the instruction
// memory port and the decode-side port.
//   slave  : the view used by fetch_unit. It receives ihit/imemload and
//            stall/redirect/redirect_pc/halt. It drives imemREN/imemaddr and
//            instr/instr_valid/npc/halted/icount.
//   master : the view used by the environment (memory + control unit).
interface fetch_unit_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] npc;
  logic        halted;
  logic [31:0] icount;

  modport slave (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, instr, instr_valid, npc, halted, icount
  );

  modport master (
    output ihit, imemload, stall, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, instr, instr_valid, npc, halted, icount
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It owns the PC and issues word reads to
// instruction memory. It holds one fetched word in a single-entry buffer for
// the control unit. It follows redirects, stops on a consumed HALT, and
// counts consumed instructions.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   fetch_unit_if.slave. It carries these signals:
//         - imem side: ihit, imemload, imemREN, imemaddr
//         - decode side: stall, redirect, redirect_pc, halt, instr,
//           instr_valid, npc, halted, icount
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            nRST,
  fetch_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] icount_q, icount_d;
  logic        consume;
  logic [31:0] redirect_pc_aligned;

  // The low two bits of a redirect target are not meaningful for word fetch.
  assign redirect_pc_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

  // The buffered word is handed over whenever it is live and not stalled.
  // This is true even when a redirect or halt happens on the same edge.
  assign consume = (state_q == VALID) && !bus.stall;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    icount_d   = icount_q;

    if (consume) begin
      icount_d = icount_q + 32'd1;
    end

    unique case (state_q)
      FETCH: begin
        // A redirect wins over a same-cycle hit. The returned word belongs to
        // the old path, so it is dropped.
        if (bus.redirect) begin
          pc_d = redirect_pc_aligned;
        end else if (bus.ihit) begin
          instr_d    = bus.imemload;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (consume && bus.halt) begin
          state_d = HALTED;
        end else if (bus.redirect) begin
          pc_d    = redirect_pc_aligned;
          state_d = FETCH;
        end else if (!bus.stall) begin
          if (bus.ihit) begin
            instr_d    = bus.imemload;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        // Only reset leaves HALTED.
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FETCH;
      pc_q       <= PC_INIT;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      icount_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      icount_q   <= icount_d;
    end
  end

  // A stalled VALID state requests nothing, because a returned word would
  // have nowhere to go.
  assign bus.imemREN     = (state_q == FETCH) || ((state_q == VALID) && !bus.stall);
  assign bus.imemaddr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == VALID);
  assign bus.npc         = instr_pc_q + 32'd4;
  assign bus.halted      = (state_q == HALTED);
  assign bus.icount      = icount_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;
  exp_t sb_q[$];

  fetch_unit_if bus ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld, input logic st,
                       input logic rd, input logic [31:0] rpc, input logic hl);
    bus.ihit        = ih;
    bus.imemload    = ld;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt        = hl;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] np);
    exp_t e;
    e.instr = ins;
    e.npc   = np;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every consume event pops one expected word from the scoreboard.
  always @(negedge CLK) begin
    if (nRST && bus.instr_valid && !bus.stall) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_instr", bus.instr, e.instr);
        chk("sb_npc", bus.npc, e.npc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) tick();

    // Reset state
    chk("rst_addr",   bus.imemaddr, 32'h0);
    chk("rst_valid",  32'(bus.instr_valid), 32'd0);
    chk("rst_instr",  bus.instr, 32'h0);
    chk("rst_npc",    bus.npc, 32'h4);
    chk("rst_icount", bus.icount, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_ren",    32'(bus.imemREN), 32'd1);
    nRST = 1'b1;

    // Back-to-back hits
    drive(1'b1, 32'h2001_0001, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("t1_ren",   32'(bus.imemREN), 32'd1);
    chk("t1_addr0", bus.imemaddr, 32'h0);
    chk("t1_vld0",  32'(bus.instr_valid), 32'd0);
    push(32'h2001_0001, 32'h4);
    tick();
    drive(1'b1, 32'h2002_0002, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("t1_addr4", bus.imemaddr, 32'h4);
    chk("t1_vld1",  32'(bus.instr_valid), 32'd1);
    chk("t1_icnt0", bus.icount, 32'd0);
    push(32'h2002_0002, 32'h8);
    tick();

    // Stall holds everything, hits ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h9999_9999, 1'b1, 1'b0, 32'h0, 1'b0); #3;
      chk("st_ren",   32'(bus.imemREN), 32'd0);
      chk("st_instr", bus.instr, 32'h2002_0002);
      chk("st_npc",   bus.npc, 32'h8);
      chk("st_addr",  bus.imemaddr, 32'h8);
      chk("st_icnt",  bus.icount, 32'd1);
      tick();
    end
    drive(1'b1, 32'h2003_0003, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("st_resume_addr", bus.imemaddr, 32'h8);
    chk("st_resume_ren",  32'(bus.imemREN), 32'd1);
    push(32'h2003_0003, 32'hC);
    tick();

    // Redirect with a same-cycle hit: the data is dropped
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0043, 1'b0); #3;
    chk("rd_icnt_pre", bus.icount, 32'd2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("rd_vld",  32'(bus.instr_valid), 32'd0);
    chk("rd_addr", bus.imemaddr, 32'h40);
    chk("rd_ren",  32'(bus.imemREN), 32'd1);
    chk("rd_icnt", bus.icount, 32'd3);
    tick();

    // Miss: four cycles without ihit in total
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #3;
      chk("miss_ren",  32'(bus.imemREN), 32'd1);
      chk("miss_addr", bus.imemaddr, 32'h40);
      chk("miss_vld",  32'(bus.instr_valid), 32'd0);
      tick();
    end
    drive(1'b1, 32'h8C22_0000, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("miss_hit_addr", bus.imemaddr, 32'h40);
    push(32'h8C22_0000, 32'h44);
    tick();

    // Halt, with redirect and ihit on the same consume edge
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h100, 1'b1); #3;
    chk("hl_vld",   32'(bus.instr_valid), 32'd1);
    chk("hl_instr", bus.instr, 32'h8C22_0000);
    chk("hl_icnt",  bus.icount, 32'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 32'h2222_2222, i[1], 1'b1, 32'h200, 1'b1); #3;
      chk("hd_halted", 32'(bus.halted), 32'd1);
      chk("hd_ren",    32'(bus.imemREN), 32'd0);
      chk("hd_vld",    32'(bus.instr_valid), 32'd0);
      chk("hd_icnt",   bus.icount, 32'd4);
      chk("hd_addr",   bus.imemaddr, 32'h44);
      chk("hd_instr",  bus.instr, 32'h8C22_0000);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    nRST = 1'b0; #3;
    chk("rr_addr",   bus.imemaddr, 32'h0);
    chk("rr_halted", 32'(bus.halted), 32'd0);
    chk("rr_icnt",   bus.icount, 32'd0);
    chk("rr_npc",    bus.npc, 32'h4);
    tick();
    nRST = 1'b1;

    // PC wrap: redirect from FETCH (hit dropped), then two hits
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0); #3;
    chk("wr_addr0", bus.imemaddr, 32'h0);
    tick();
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("wr_addr_top", bus.imemaddr, 32'hFFFF_FFFC);
    chk("wr_vld0",     32'(bus.instr_valid), 32'd0);
    push(32'hAAAA_0001, 32'h0);
    tick();
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("wr_addr_wrap", bus.imemaddr, 32'h0);
    chk("wr_npc_wrap",  bus.npc, 32'h0);
    push(32'hBBBB_0002, 32'h4);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0); #3;
    chk("wr_addr4", bus.imemaddr, 32'h4);
    chk("wr_npc4",  bus.npc, 32'h4);
    tick();
    #3;
    chk("wr_vld_end", 32'(bus.instr_valid), 32'd0);
    chk("wr_icnt",    bus.icount, 32'd2);
    tick();
    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the PC and issues word reads to the instruction memory/cache port (imemREN/imemaddr, ihit/imemload).
- Holds one fetched instruction in a single-entry buffer and presents it as instr with a valid flag to the decode/control stage.
- Accepts PC redirects for branches, jumps and JR from downstream, stops fetching on HALT, and counts retired fetches.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous active-low reset.
ihit  input  1  instruction memory returns data for imemaddr this cycle.
imemload  input  32  instruction word, valid when ihit=1.
imemREN  output  1  instruction read request.
imemaddr  output  32  word-aligned fetch address (= pc).
stall  input  1  downstream cannot accept the held instruction this cycle.
redirect  input  1  downstream orders a PC change this cycle.
redirect_pc  input  32  new PC; bits [1:0] ignored and treated as 00.
halt  input  1  held instruction is HALT.
instr  output  32  buffered instruction word to the control unit.
instr_valid  output  1  instr holds a live instruction.
npc  output  32  address of buffered instruction + 4 (link value / branch base).
halted  output  1  sticky; fetch stopped.
icount  output  32  number of instructions consumed since reset.

Behaviour:
- Reset (nRST=0, async): pc=PC_INIT; instr=0; instr_pc=0 (npc=4); instr_valid=0; icount=0; halted=0; state=FETCH. imemREN=1 in the first cycle after reset release.
- Consume event: instr_valid && !stall at a rising edge.
- State FETCH (buffer empty):
  - Outputs: imemREN=1, imemaddr=pc, instr_valid=0.
  - On ihit: instr<=imemload, instr_pc<=pc, pc<=pc+4, go to VALID.
  - On !ihit: stay in FETCH, hold pc.
- State VALID (buffer full):
  - Outputs: instr_valid=1; imemREN = !stall (combinational).
  - If stall: hold everything; any ihit is ignored.
  - If !stall && ihit: load next instr and instr_pc, pc<=pc+4, stay in VALID. Back-to-back hits give 1 instruction/cycle.
  - If !stall && !ihit: go to FETCH.
  - Every consume event: icount<=icount+1 (wraps at 2^32).
- Redirect: redirect sampled high in FETCH or VALID.
  - pc<={redirect_pc[31:2],2'b00}; instr_valid<=0; go to FETCH.
  - Any same-cycle ihit data is discarded; pc is not incremented.
  - If it coincides with a consume event, icount still increments.
- Halt: halt && consume event.
  - icount increments; go to HALTED.
  - halt takes priority over redirect and ihit in the same cycle.
- HALTED: imemREN=0, instr_valid=0, halted=1. pc, instr and icount frozen. All inputs ignored; only nRST exits.
- Priority at each edge: nRST > halt > redirect > stall > ihit.
- PC arithmetic: 32-bit unsigned, wraps silently (0xFFFFFFFC+4 = 0x00000000). imemaddr[1:0] is always 00.
- halt or redirect with instr_valid=0: halt ignored; redirect still applies.
- Reset mid-fetch: the outstanding request is abandoned; the next fetch is from PC_INIT.
- Latency: ihit in cycle N → instr_valid=1 with that word in cycle N+1.

Test Plan:
- Reset, then ihit=1 every cycle with imemload=0x20010001,0x20020002,0x20030003, stall=0 → imemaddr 0,4,8; instr matches in successive cycles; npc 4,8,12; icount increments every cycle.
- stall=1 for 3 cycles while instr=0x20020002 is valid, ihit=1 → imemREN=0; instr, npc=8 and pc=8 held; icount unchanged; after stall drops, the next instr comes from 0x8.
- redirect=1, redirect_pc=0x00000043 in the same cycle as ihit → ihit data dropped; instr_valid=0 next cycle; imemaddr=0x40; the fetch from 0x40 returns the next valid instr.
- ihit delayed 4 cycles (miss) in FETCH → imemREN stays 1 and imemaddr stable; instr_valid=1 exactly one cycle after ihit.
- halt=1 with redirect=1 and ihit=1 on a consume edge → halted=1; imemREN=0; icount +1 only; pc unchanged; state holds for 10 cycles; nRST pulse returns to pc=PC_INIT, halted=0, icount=0.
- redirect_pc=0xFFFFFFFC with 2 ihits → fetch addresses 0xFFFFFFFC then 0x00000000; npc for the first instruction = 0x00000000.
